// File: rtl/inst_queue_pkg.sv
// Shared widths, constants and occupancy status for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int IQ_INST_WIDTH = 32;
  localparam int IQ_PC_WIDTH   = 32;
  localparam logic [31:0] IQ_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Occupancy status is a pure function of the held count.
  function automatic occ_e occ_of(input int unsigned count, input int unsigned depth);
    if (count == 0) return OCC_EMPTY;
    else if (count >= depth) return OCC_FULL;
    else return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/inst_queue_storage.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module iq_storage
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = IQ_INST_WIDTH + IQ_PC_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// In-order instruction buffer between fetch and decode with busy back-pressure,
// single-cycle flush and a sticky overflow flag.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INST_WIDTH  = IQ_INST_WIDTH,
  parameter int PC_WIDTH    = IQ_PC_WIDTH,
  parameter int BUSY_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INST_WIDTH-1:0]      in_inst,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_WIDTH-1:0]      out_inst,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PC_WIDTH + INST_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] BUSY_CNT = CNT_W'(DEPTH - BUSY_MARGIN);

  // Handshake: an entry transfers to decode on any cycle where out_valid and
  // out_ready are both high and flush is low; the head holds stable otherwise.
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ENT_W-1:0] rd_data;
  logic             push, pop, drop;
  occ_e             occ;

  assign occ       = occ_of(int'(count), DEPTH);
  assign out_valid = (occ != OCC_EMPTY);
  assign pop       = out_valid && out_ready && !flush;
  assign push      = in_valid && !flush && ((occ != OCC_FULL) || pop);
  assign drop      = in_valid && !flush && (count == FULL_CNT) && !pop;
  assign busy      = (count >= BUSY_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (drop) overflow_err <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  iq_storage #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_pc, in_inst}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Storage is unreset, so the head is masked to zero whenever nothing is valid.
  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = rd_data[INST_WIDTH-1:0];
      out_pc   = rd_data[ENT_W-1:INST_WIDTH];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int PW    = 32;
  localparam int MARG  = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, reset, flush, in_valid, out_ready;
  logic [IW-1:0] in_inst, out_inst;
  logic [PW-1:0] in_pc, out_pc;
  logic          busy, out_valid, overflow_err;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW+IW-1:0] exp_q[$];
  logic             exp_ovf;

  inst_queue #(.DEPTH(DEPTH), .INST_WIDTH(IW), .PC_WIDTH(PW), .BUSY_MARGIN(MARG)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .count        (count),
    .overflow_err (overflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [PW+IW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({tag, ".count"},     64'(count),        64'(exp_q.size()));
    check({tag, ".out_valid"}, 64'(out_valid),    64'(exp_q.size() != 0));
    check({tag, ".busy"},      64'(busy),         64'(exp_q.size() >= DEPTH - MARG));
    check({tag, ".overflow"},  64'(overflow_err), 64'(exp_ovf));
    check({tag, ".out_inst"},  64'(out_inst),     64'(head[IW-1:0]));
    check({tag, ".out_pc"},    64'(out_pc),       64'(head[PW+IW-1:IW]));
  endtask

  task automatic drive(input logic iv, input logic [IW-1:0] inst, input logic [PW-1:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  // One clock: the reference model applies the queue rules to the inputs
  // presented before the edge, then every output is compared after it.
  task automatic cycle(input string tag);
    bit full, m_pop, m_push;
    full   = (exp_q.size() == DEPTH);
    m_pop  = (exp_q.size() > 0) && out_ready && !flush;
    m_push = in_valid && !flush && (!full || m_pop);
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (in_valid && full && !m_pop) exp_ovf = 1'b1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({in_pc, in_inst});
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    #2;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    exp_ovf = 1'b0;
    #1;
    do_reset();

    // fill with out_ready low; head must stay A0
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hA0 + i, i, 0, 0);
      cycle("fill");
    end
    check("fill.head_hold", 64'(out_inst), 64'h0000_00A0);

    // full with simultaneous push and pop
    drive(1, 32'hB0, 32'h10, 1, 0);
    cycle("full_pushpop");
    check("full_pushpop.ovf", 64'(overflow_err), 64'd0);

    // drain in order
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, 1, 0);
      check("drain.order", 64'(out_inst), (i < 3) ? 64'(32'hA1 + i) : 64'h0000_00B0);
      cycle("drain");
    end

    // refill and overflow with out_ready low
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hC0 + i, 32'h20 + i, 0, 0);
      cycle("refill");
    end
    drive(1, 32'hDD, 32'h99, 0, 0);
    cycle("overflow");
    check("overflow.set", 64'(overflow_err), 64'd1);
    drive(0, '0, '0, 0, 1);
    cycle("flush_keeps_ovf");
    check("flush.ovf_sticky", 64'(overflow_err), 64'd1);

    // streaming with out_ready held high, pointers wrap
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hE0 + i, 32'h40 + i, 1, 0);
      cycle("stream");
      check("stream.head", 64'(out_inst), 64'(32'hE0 + i));
    end
    drive(0, '0, '0, 1, 0);
    cycle("stream_tail");

    // flush with three queued plus same-cycle push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hF0 + i, 32'h60 + i, 0, 0);
      cycle("preflush");
    end
    drive(1, 32'hFF, 32'h77, 1, 1);
    cycle("flush");
    check("flush.count0", 64'(count), 64'd0);

    // asynchronous reset between edges with two queued
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h50 + i, 32'h80 + i, 0, 0);
      cycle("pre_areset");
    end
    drive(0, '0, '0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_all("areset");
    #1;
    reset = 1'b0;
    drive(1, 32'h1234, 32'h500, 0, 0);
    cycle("post_areset");
    check("post_areset.inst", 64'(out_inst), 64'h0000_1234);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom, $urandom,
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction buffer between the fetch stage and decode.
- Captures each fetched instruction word with its PC and presents it in order to decode over a valid/ready handshake.
- Provides a `busy` back-pressure signal that fetch samples before starting its next memory request.
- Supports a single-cycle flush for redirects and branches.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- INST_WIDTH, 32, instruction word width.
- PC_WIDTH, 32, program-counter width carried with each entry.
- BUSY_MARGIN, 1, free entries reserved for fetch request latency; range 0..DEPTH-1.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries (redirect).
- in_valid  input  1  fetch presents a completed instruction this cycle.
- in_inst  input  INST_WIDTH  instruction word from fetch.
- in_pc  input  PC_WIDTH  PC of in_inst.
- busy  output  1  fetch must not issue a new request while high.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts head entry this cycle.
- out_inst  output  INST_WIDTH  head instruction word.
- out_pc  output  PC_WIDTH  head PC.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow_err  output  1  sticky; a push was dropped because the queue was full.

Behaviour:
- Reset is asynchronous and active-high, on clock clk. During reset:
  - wr_ptr, rd_ptr and count are 0.
  - overflow_err = 0, out_valid = 0, busy = 0.
  - out_inst and out_pc are 0. Storage contents are don't-care.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is held explicitly, one bit wider than the pointers, to distinguish full from empty.
- pop = out_valid && out_ready && !flush.
- push = in_valid && !flush && (count < DEPTH || pop).
  - When full, a simultaneous pop frees the slot in the same cycle, so a push alongside a pop is accepted.
- On push: mem[wr_ptr] <= {in_pc, in_inst}; wr_ptr increments.
- On pop: rd_ptr increments.
- count update:
  - count += 1 on push only.
  - count -= 1 on pop only.
  - count unchanged on both or neither.
- Outputs:
  - out_valid = (count != 0).
  - out_inst and out_pc come combinationally from mem[rd_ptr], read from registered state only.
  - When out_valid = 0, out_inst and out_pc are driven to 0.
- Latency: an entry pushed at edge N is visible with out_valid = 1 after edge N; there is no bypass when empty. Minimum in-to-out is 1 cycle.
- Handshake: out_inst and out_pc hold stable while out_valid && !out_ready. Decode may hold out_ready high continuously.
- busy = (count >= DEPTH - BUSY_MARGIN), derived from the registered count only.
  - BUSY_MARGIN = 0 means busy only when full.
- Dropped push: in_valid && !flush && count == DEPTH && !pop.
  - The entry is discarded and overflow_err is set; it stays set until reset.
  - Flush does not clear overflow_err.
- Flush:
  - On the next edge, wr_ptr = rd_ptr = 0 and count = 0.
  - Any same-cycle push or pop is ignored; an ignored push does not set overflow_err.
  - out_valid is 0 from the cycle after flush.
- Reset asserted mid-operation clears state immediately regardless of handshakes. The first push is accepted on the first edge after reset deasserts.
- Internal occupancy status (EMPTY / PARTIAL / FULL) is derived from count. It is not a separate state register.

Decomposition:
- Shared defines:
  - `INST_WIDTH` (used by fetch/opcode).
  - `PC_WIDTH`.
  - `NOP_INST` = 32'h0000_0013, used by decode when out_valid = 0.
- Sub-module: iq_storage, a DEPTH x (PC_WIDTH+INST_WIDTH) register array with one synchronous write port and one asynchronous read port, no reset.
- All pointer, count and handshake logic stays in inst_queue.

Test Plan:
- Reset then 4 pushes, PCs 0..3 with insts 32'hA0..32'hA3, out_ready=0 -> count=4, busy=1 from count=3 (DEPTH=4, MARGIN=1), out_inst=32'hA0 held stable.
- Queue full, in_valid=1 (inst 32'hB0), out_ready=1 same cycle -> pop 32'hA0, push accepted, count stays 4, overflow_err=0, later drains A1,A2,A3,B0 in order.
- Queue full, in_valid=1, out_ready=0 -> entry dropped, count=4, overflow_err=1 and stays 1 after flush.
- Push 6 entries with out_ready=1 continuously -> pointers wrap past 3, out sequence matches input order with no gaps, count never exceeds 1.
- 3 entries queued, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=0, no pop counted, overflow_err unchanged.
- Assert reset asynchronously mid-stream (count=2, between edges) -> count, out_valid and busy go to 0 immediately. First push after deassert appears at out_inst one cycle later.
